dragster_spi_arbiter: RTL and testbench
=======================================

Name: dragster_spi_arbiter

Overview:
- Shares one external SPI link to the Dragster linear image sensor between two requesters:
  - req0: the power-up register-init sequencer.
  - req1: the runtime host or config path.
- Arbitrates, serialises each 16-bit word LSB-first under the selected slave select, appends the sensor's extra SCK cycles, then enforces an inter-word gap.
- Captures MISO and returns it with the requester ID.
- Sits between the config sources and the sensor pins.

Parameters:
- DATA_WIDTH, 16: bits per transaction.
- EXTENDED_CLOCKS, 3: extra SCK periods after the last data bit, SS still asserted.
- CLK_DIV, 2: SCK half-period in clk cycles; legal values are 1 and above.
- GAP_CYCLES, 4: idle clk cycles with SS deasserted between transactions; 0 is legal.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low.
- req0_valid, input, 1: requester 0 has a word.
- req0_data, input, DATA_WIDTH: requester 0 word.
- req0_ss, input, 2: requester 0 slave select, active-low.
- req0_ready, output, 1: requester 0 word accepted this cycle.
- req1_valid, input, 1: requester 1 has a word.
- req1_data, input, DATA_WIDTH: requester 1 word.
- req1_ss, input, 2: requester 1 slave select, active-low.
- req1_ready, output, 1: requester 1 word accepted this cycle.
- resp_valid, output, 1: one-cycle pulse; rdata and resp_id are valid.
- resp_id, output, 1: requester that owned the finished transaction.
- rdata, output, DATA_WIDTH: MISO bits captured LSB-first.
- busy, output, 1: high in any state other than IDLE.
- spi_sck, output, 1: external SCK; idles low.
- spi_mosi, output, 1: external MOSI.
- spi_miso, input, 1: external MISO.
- spi_ss, output, 2: external slave select, active-low.

Behaviour:
- Reset (asynchronous, active-low), all registers cleared:
  - spi_ss=2'b11, spi_sck=0, spi_mosi=0.
  - req0_ready=0, req1_ready=0, resp_valid=0, resp_id=0, rdata=0, busy=0.
  - last_grant=1, state=IDLE.
  - Reset mid-transaction aborts immediately: SS deasserts and no response is issued.
- States: IDLE, SHIFT, EXTEND, GAP.
- IDLE and arbitration:
  - reqN_ready is combinational: high only in IDLE for the granted requester.
  - A handshake occurs when valid and ready are both high. Valid must stay high with stable data until ready.
  - Only one requester is valid: that requester is granted.
  - Both are valid: grant goes to the requester other than last_grant (round-robin). After reset, req0 wins the first tie.
  - On handshake: latch data, ss and id; update last_grant; go to SHIFT.
  - Next cycle: spi_ss=latched ss, spi_mosi=bit 0.
- SHIFT:
  - SCK is low for CLK_DIV cycles, then high for CLK_DIV cycles, per bit.
  - MOSI changes only while SCK is low, at the start of each bit.
  - MISO is sampled into rdata[bit] in the cycle SCK rises.
  - After bit DATA_WIDTH-1 falls: go to EXTEND, or to GAP if EXTENDED_CLOCKS=0.
- EXTEND:
  - EXTENDED_CLOCKS full SCK periods, MOSI=0, SS held.
  - MISO is ignored.
- GAP entry:
  - In the first cycle: SS=2'b11, SCK=0, MOSI=0.
  - resp_valid pulses for one cycle with rdata and resp_id.
- GAP:
  - Lasts GAP_CYCLES cycles, then go to IDLE.
  - With GAP_CYCLES=0: the resp_valid cycle is the only cycle, then IDLE.
  - The earliest next handshake is in the IDLE cycle.
- Transaction timing:
  - Handshake cycle to resp_valid: 1 + 2·CLK_DIV·(DATA_WIDTH+EXTENDED_CLOCKS) cycles.
  - Full period: that value + max(GAP_CYCLES,1).
- Counters:
  - Bit counter width is $clog2(DATA_WIDTH+EXTENDED_CLOCKS)+1; no wrap is possible within a transaction.
  - Divider counter is reloaded at every SCK edge.
- Data stability: requester data and ss changing after the handshake have no effect.
- req*_ss=2'b11 is accepted: the transaction runs with SS deasserted (dummy clocks) and still responds.
- busy=1 in SHIFT, EXTEND and GAP.

Optional Feature:
- DRAGSTER_SPI_PRIORITY_EN defined:
  - Fixed priority: req0 always wins when both requesters are valid.
  - last_grant is unused; req1 can starve while req0 streams.
- DRAGSTER_SPI_PRIORITY_EN undefined: round-robin as above.

Test Plan:
- Single req0: data=16'hA5C3, ss=2'b10, defaults.
  - MOSI LSB-first 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 across 16 SCK rises.
  - Then 3 extra SCK periods.
  - resp_valid 77 cycles after the handshake with resp_id=0.
  - Next handshake possible 81 cycles after the first.
- MISO loopback (spi_miso tied to spi_mosi): req1 data=16'h1234 -> rdata=16'h1234, resp_id=1.
- Both valid continuously after reset:
  - Grants alternate 0,1,0,1.
  - Each ready is a one-cycle pulse.
  - SS never asserted during GAP (4 cycles of 2'b11 between words).
  - With DRAGSTER_SPI_PRIORITY_EN: only req0 is granted.
- reset low during SHIFT bit 7:
  - Same cycle: spi_ss=2'b11, sck=0, busy=0.
  - No resp_valid.
  - After release, the pending req0 is granted first.
- Corners, CLK_DIV=1, EXTENDED_CLOCKS=0, GAP_CYCLES=0:
  - SCK toggles every cycle.
  - resp_valid at cycle 33 after the handshake.
  - Back-to-back handshake at cycle 34.
- req0_ss=2'b11: 16+3 SCK periods are issued with spi_ss=2'b11, and resp_valid still pulses.

Source files
------------

// File: rtl/dragster_spi_arbiter.sv
// dragster_spi_arbiter
// Shares one SPI link to the Dragster linear image sensor between two
// requesters (req0: power-up init sequencer, req1: runtime host/config).
// Each accepted word is shifted LSB-first under the requester's slave
// select, followed by EXTENDED_CLOCKS extra SCK periods. Then an idle
// gap follows with SS deasserted. Captured MISO is returned with the
// requester ID.
//
// Ports:
//   clk, reset (async, active-low)
//   req0_valid/req0_data/req0_ss/req0_ready  requester 0 word handshake
//   req1_valid/req1_data/req1_ss/req1_ready  requester 1 word handshake
//   resp_valid/resp_id/rdata                 one-cycle response pulse
//   busy                                     high in any state but IDLE
//   spi_sck/spi_mosi/spi_miso/spi_ss         sensor pins (SS active-low)
//
// Build option: define DRAGSTER_SPI_PRIORITY_EN for fixed priority (req0
// always wins a tie). Otherwise ties are resolved round-robin.
module dragster_spi_arbiter #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned EXTENDED_CLOCKS = 3,
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned GAP_CYCLES      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [1:0]            req0_ss,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic [1:0]            req1_ss,
  output logic                  req1_ready,
  output logic                  resp_valid,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic [1:0]            spi_ss
);

  localparam int unsigned TOTAL_BITS = DATA_WIDTH + EXTENDED_CLOCKS;
  localparam int unsigned BIT_W      = $clog2(TOTAL_BITS) + 1;
  localparam int unsigned DIV_W      = $clog2(CLK_DIV) + 1;
  // The response cycle always belongs to GAP, so GAP lasts at least one cycle.
  localparam int unsigned GAP_TOTAL  = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int unsigned GAP_W      = $clog2(GAP_TOTAL) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, EXTEND, GAP} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  id_q, id_d;
  logic                  sck_d, mosi_d, resp_valid_d, resp_id_d, busy_d;
  logic [1:0]            ss_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  sel1;

  // Grant selection: sel1 means requester 1 wins this IDLE cycle.
`ifdef DRAGSTER_SPI_PRIORITY_EN
  assign sel1 = req1_valid && !req0_valid;
`else
  logic last_grant_q, last_grant_d;
  assign sel1 = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
`endif

  // Next-state, SCK generation, shift/capture and response logic.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    id_d         = id_q;
    sck_d        = spi_sck;
    mosi_d       = spi_mosi;
    ss_d         = spi_ss;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id;
    rdata_d      = rdata;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
`ifndef DRAGSTER_SPI_PRIORITY_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Gated by reset so no handshake is signalled while registers are held.
        req0_ready = reset && req0_valid && !sel1;
        req1_ready = reset && req1_valid && sel1;
        if (req0_valid || req1_valid) begin
          state_d = SHIFT;
          id_d    = sel1;
          tx_d    = sel1 ? (req1_data >> 1) : (req0_data >> 1);
          mosi_d  = sel1 ? req1_data[0] : req0_data[0];
          ss_d    = sel1 ? req1_ss : req0_ss;
          sck_d   = 1'b0;
          div_d   = DIV_W'(CLK_DIV - 1);
          bit_d   = '0;
          rx_d    = '0;
`ifndef DRAGSTER_SPI_PRIORITY_EN
          last_grant_d = sel1;
`endif
        end
      end

      SHIFT, EXTEND: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          div_d = DIV_W'(CLK_DIV - 1);
          sck_d = !spi_sck;
          if (!spi_sck) begin
            // Rising edge: capture MISO for data bits only.
            if (state_q == SHIFT) rx_d = {spi_miso, rx_q[DATA_WIDTH-1:1]};
          end else if (bit_q == BIT_W'(TOTAL_BITS - 1)) begin
            // Falling edge of the final period: release the bus and respond.
            state_d      = GAP;
            ss_d         = 2'b11;
            mosi_d       = 1'b0;
            resp_valid_d = 1'b1;
            resp_id_d    = id_q;
            rdata_d      = rx_q;
            gap_d        = GAP_W'(GAP_TOTAL - 1);
          end else begin
            bit_d = bit_q + BIT_W'(1);
            if (bit_q < BIT_W'(DATA_WIDTH - 1)) begin
              mosi_d = tx_q[0];
              tx_d   = tx_q >> 1;
            end else begin
              state_d = EXTEND;
              mosi_d  = 1'b0;
            end
          end
        end
      end

      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      id_q       <= 1'b0;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_ss     <= 2'b11;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
`ifndef DRAGSTER_SPI_PRIORITY_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      id_q       <= id_d;
      spi_sck    <= sck_d;
      spi_mosi   <= mosi_d;
      spi_ss     <= ss_d;
      resp_valid <= resp_valid_d;
      resp_id    <= resp_id_d;
      rdata      <= rdata_d;
      busy       <= busy_d;
`ifndef DRAGSTER_SPI_PRIORITY_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_dragster_spi_arbiter.sv
// Directed testbench for dragster_spi_arbiter: default-parameter instance
// plus a CLK_DIV=1 / EXTENDED_CLOCKS=0 / GAP_CYCLES=0 corner instance.
`timescale 1ns/1ps
module tb_dragster_spi_arbiter;

  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_data, req1_data, rdata;
  logic [1:0]    req0_ss, req1_ss, spi_ss;
  logic          resp_valid, resp_id, busy, spi_sck, spi_mosi, spi_miso;
  logic          loopback, miso_drv;

  assign spi_miso = loopback ? spi_mosi : miso_drv;

  dragster_spi_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ss(req0_ss), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ss(req1_ss), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .rdata(rdata), .busy(busy),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss(spi_ss)
  );

  logic          c_req0_valid, c_req0_ready, c_req1_valid, c_req1_ready;
  logic [DW-1:0] c_req0_data, c_req1_data, c_rdata;
  logic [1:0]    c_req0_ss, c_req1_ss, c_spi_ss;
  logic          c_resp_valid, c_resp_id, c_busy, c_spi_sck, c_spi_mosi, c_spi_miso;

  dragster_spi_arbiter #(.DATA_WIDTH(16), .EXTENDED_CLOCKS(0), .CLK_DIV(1), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .reset(reset),
    .req0_valid(c_req0_valid), .req0_data(c_req0_data), .req0_ss(c_req0_ss), .req0_ready(c_req0_ready),
    .req1_valid(c_req1_valid), .req1_data(c_req1_data), .req1_ss(c_req1_ss), .req1_ready(c_req1_ready),
    .resp_valid(c_resp_valid), .resp_id(c_resp_id), .rdata(c_rdata), .busy(c_busy),
    .spi_sck(c_spi_sck), .spi_mosi(c_spi_mosi), .spi_miso(c_spi_miso), .spi_ss(c_spi_ss)
  );

  // Waits (bounded) for a handshake on the default instance; called at a negedge.
  task automatic wait_hs(output logic ok, output logic gid);
    ok = 1'b0; gid = 1'b0;
    #1;
    for (int n = 0; n < 300; n++) begin
      if (req0_valid && req0_ready) begin ok = 1'b1; gid = 1'b0; break; end
      if (req1_valid && req1_ready) begin ok = 1'b1; gid = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic drain(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    got = {spi_ss, spi_sck, spi_mosi, busy, resp_valid, req0_ready, req1_ready};
    vecs++; if (got !== 8'b1100_0000) begin errs++; $display("FAIL reset_outputs: got %b expected 11000000", got); end
    vecs++; if (rdata !== 16'h0000 || resp_id !== 1'b0) begin errs++; $display("FAIL reset_resp: got rdata=%h id=%b expected 0000/0", rdata, resp_id); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    logic ok, gid, got_resp, stable_ok, ss_ok, prev_sck, prev_mosi;
    int h, rises;
    w = 16'hA5C3;
    miso_drv = 1'b1;
    req0_data = w; req0_ss = 2'b10; req0_valid = 1'b1;
    wait_hs(ok, gid);
    h = cyc;
    vecs++; if (!ok || gid !== 1'b0) begin errs++; $display("FAIL single_grant: got ok=%b id=%b expected 1/0", ok, gid); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req0_data = 16'h0000; req0_ss = 2'b11;
    rises = 0; prev_sck = 1'b0; prev_mosi = 1'b0; got_resp = 1'b0; stable_ok = 1'b1; ss_ok = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n == 0) begin
        vecs++; if (spi_ss !== 2'b10 || spi_mosi !== 1'b1 || spi_sck !== 1'b0) begin
          errs++; $display("FAIL single_first_cycle: got ss=%b mosi=%b sck=%b expected 10/1/0", spi_ss, spi_mosi, spi_sck);
        end
      end
      if (resp_valid) begin got_resp = 1'b1; break; end
      if (spi_sck && !prev_sck) begin
        if (rises < 16) begin
          vecs++; if (spi_mosi !== w[rises]) begin errs++; $display("FAIL mosi_bit%0d: got %b expected %b", rises, spi_mosi, w[rises]); end
        end
        rises++;
      end
      if (spi_ss !== 2'b10) ss_ok = 1'b0;
      if (spi_sck && prev_sck && spi_mosi !== prev_mosi) stable_ok = 1'b0;
      prev_sck = spi_sck; prev_mosi = spi_mosi;
    end
    vecs++; if (!got_resp || (cyc - h) != 77) begin errs++; $display("FAIL single_latency: got resp=%b at %0d expected 1 at 77", got_resp, cyc - h); end
    vecs++; if (rises != 19) begin errs++; $display("FAIL single_sck_count: got %0d expected 19", rises); end
    vecs++; if (!ss_ok || !stable_ok) begin errs++; $display("FAIL single_ss_mosi_stable: got ss_ok=%b stable=%b expected 1/1", ss_ok, stable_ok); end
    vecs++; if (resp_id !== 1'b0 || rdata !== 16'hFFFF || spi_ss !== 2'b11 || busy !== 1'b1) begin
      errs++; $display("FAIL single_resp: got id=%b rdata=%h ss=%b busy=%b expected 0/ffff/11/1", resp_id, rdata, spi_ss, busy);
    end
    req0_data = 16'h0001; req0_ss = 2'b10; req0_valid = 1'b1;
    wait_hs(ok, gid);
    vecs++; if (!ok || (cyc - h) != 81) begin errs++; $display("FAIL single_next_hs: got ok=%b at %0d expected 1 at 81", ok, cyc - h); end
    @(posedge clk); #1 req0_valid = 1'b0;
    drain(ok);
    vecs++; if (!ok) begin errs++; $display("FAIL single_drain: got busy=%b expected 0", busy); end
    miso_drv = 1'b0;
  endtask

  task automatic test_loopback();
    logic ok, gid, got_resp;
    loopback = 1'b1;
    req1_data = 16'h1234; req1_ss = 2'b01; req1_valid = 1'b1;
    wait_hs(ok, gid);
    vecs++; if (!ok || gid !== 1'b1) begin errs++; $display("FAIL loop_grant: got ok=%b id=%b expected 1/1", ok, gid); end
    @(posedge clk); #1;
    req1_valid = 1'b0; req1_data = 16'hFFFF; req1_ss = 2'b00;
    got_resp = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (resp_valid) begin got_resp = 1'b1; break; end
    end
    vecs++; if (!got_resp || rdata !== 16'h1234 || resp_id !== 1'b1) begin
      errs++; $display("FAIL loop_rdata: got resp=%b rdata=%h id=%b expected 1/1234/1", got_resp, rdata, resp_id);
    end
    loopback = 1'b0;
    drain(ok);
    vecs++; if (!ok) begin errs++; $display("FAIL loop_drain: got busy=%b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    logic ok, gid, exp, got_resp;
    int gap_cnt;
    reset = 1'b0; @(negedge clk); reset = 1'b1; @(negedge clk);
    req0_data = 16'h00F0; req0_ss = 2'b10; req0_valid = 1'b1;
    req1_data = 16'h0F00; req1_ss = 2'b01; req1_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
`ifdef DRAGSTER_SPI_PRIORITY_EN
      exp = 1'b0;
`else
      exp = (g % 2) != 0;
`endif
      wait_hs(ok, gid);
      vecs++; if (!ok || gid !== exp || (req0_ready && req1_ready)) begin
        errs++; $display("FAIL rr_grant%0d: got ok=%b id=%b r0=%b r1=%b expected id=%b one ready", g, ok, gid, req0_ready, req1_ready, exp);
      end
      @(negedge clk);
      vecs++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errs++; $display("FAIL rr_ready_pulse%0d: got %b%b expected 00", g, req0_ready, req1_ready);
      end
      @(negedge clk);
      vecs++; if (spi_ss !== (exp ? 2'b01 : 2'b10)) begin
        errs++; $display("FAIL rr_ss%0d: got %b expected %b", g, spi_ss, exp ? 2'b01 : 2'b10);
      end
      if (g == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      got_resp = 1'b0;
      for (int n = 0; n < 200; n++) begin
        if (resp_valid) begin got_resp = 1'b1; break; end
        @(negedge clk);
      end
      gap_cnt = 0;
      for (int n = 0; n < 20 && busy; n++) begin
        if (spi_ss === 2'b11) gap_cnt++;
        @(negedge clk);
      end
      vecs++; if (!got_resp || gap_cnt != 4 || spi_ss !== 2'b11) begin
        errs++; $display("FAIL rr_gap%0d: got resp=%b gap_ss_cycles=%0d expected 1/4", g, got_resp, gap_cnt);
      end
    end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rr_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic ok, gid, prev_sck, reached, resp_seen, got_resp;
    int rises;
    req0_data = 16'h5A5A; req0_ss = 2'b10; req0_valid = 1'b1; req1_valid = 1'b0;
    miso_drv = 1'b1;
    wait_hs(ok, gid);
    vecs++; if (!ok || gid !== 1'b0) begin errs++; $display("FAIL mid_grant: got ok=%b id=%b expected 1/0", ok, gid); end
    rises = 0; prev_sck = 1'b0; reached = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (spi_sck && !prev_sck) rises++;
      prev_sck = spi_sck;
      if (rises == 8) begin reached = 1'b1; break; end
    end
    vecs++; if (!reached || busy !== 1'b1 || spi_ss !== 2'b10) begin
      errs++; $display("FAIL mid_bit7: got reached=%b busy=%b ss=%b expected 1/1/10", reached, busy, spi_ss);
    end
    reset = 1'b0;
    #1;
    vecs++; if (spi_ss !== 2'b11 || spi_sck !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL mid_abort: got ss=%b sck=%b busy=%b expected 11/0/0", spi_ss, spi_sck, busy);
    end
    req1_valid = 1'b1; req1_data = 16'h0000; req1_ss = 2'b01;
    resp_seen = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      if (resp_valid || req0_ready || req1_ready) resp_seen = 1'b1;
    end
    vecs++; if (resp_seen) begin errs++; $display("FAIL mid_no_resp: got resp/ready during reset=1 expected 0"); end
    reset = 1'b1;
    wait_hs(ok, gid);
    vecs++; if (!ok || gid !== 1'b0) begin errs++; $display("FAIL mid_regrant: got ok=%b id=%b expected 1/0", ok, gid); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    got_resp = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (resp_valid) begin got_resp = 1'b1; break; end
    end
    vecs++; if (!got_resp || resp_id !== 1'b0 || rdata !== 16'hFFFF) begin
      errs++; $display("FAIL mid_resp: got resp=%b id=%b rdata=%h expected 1/0/ffff", got_resp, resp_id, rdata);
    end
    drain(ok);
    vecs++; if (!ok) begin errs++; $display("FAIL mid_drain: got busy=%b expected 0", busy); end
    miso_drv = 1'b0;
  endtask

  task automatic test_ss_dummy();
    logic ok, gid, got_resp, ss_ok, prev_sck;
    int rises;
    req0_data = 16'h3C3C; req0_ss = 2'b11; req0_valid = 1'b1;
    wait_hs(ok, gid);
    vecs++; if (!ok || gid !== 1'b0) begin errs++; $display("FAIL dummy_grant: got ok=%b id=%b expected 1/0", ok, gid); end
    @(posedge clk); #1 req0_valid = 1'b0;
    rises = 0; prev_sck = 1'b0; got_resp = 1'b0; ss_ok = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (spi_ss !== 2'b11) ss_ok = 1'b0;
      if (resp_valid) begin got_resp = 1'b1; break; end
      if (spi_sck && !prev_sck) rises++;
      prev_sck = spi_sck;
    end
    vecs++; if (!got_resp || rises != 19 || !ss_ok || resp_id !== 1'b0) begin
      errs++; $display("FAIL dummy_clocks: got resp=%b rises=%0d ss_ok=%b id=%b expected 1/19/1/0", got_resp, rises, ss_ok, resp_id);
    end
    drain(ok);
    vecs++; if (!ok) begin errs++; $display("FAIL dummy_drain: got busy=%b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic ok, toggle_ok;
    int h;
    c_req0_data = 16'hBEEF; c_req0_ss = 2'b10; c_req0_valid = 1'b1;
    ok = 1'b0;
    #1;
    for (int n = 0; n < 50; n++) begin
      if (c_req0_ready) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    h = cyc;
    vecs++; if (!ok) begin errs++; $display("FAIL c_grant: got ready=%b expected 1", c_req0_ready); end
    toggle_ok = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (c_spi_sck !== ((k % 2) == 0) || c_spi_ss !== 2'b10) toggle_ok = 1'b0;
    end
    vecs++; if (!toggle_ok) begin errs++; $display("FAIL c_sck_toggle: got toggle_ok=%b expected 1", toggle_ok); end
    @(negedge clk);
    vecs++; if (c_resp_valid !== 1'b1 || (cyc - h) != 33 || c_spi_ss !== 2'b11 || c_rdata !== 16'h0000) begin
      errs++; $display("FAIL c_resp33: got resp=%b at %0d ss=%b rdata=%h expected 1 at 33/11/0000", c_resp_valid, cyc - h, c_spi_ss, c_rdata);
    end
    @(negedge clk);
    vecs++; if (c_req0_ready !== 1'b1 || c_busy !== 1'b0 || c_resp_valid !== 1'b0 || (cyc - h) != 34) begin
      errs++; $display("FAIL c_hs34: got ready=%b busy=%b resp=%b at %0d expected 1/0/0 at 34", c_req0_ready, c_busy, c_resp_valid, cyc - h);
    end
    @(posedge clk); #1 c_req0_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!c_busy) begin ok = 1'b1; break; end
    end
    vecs++; if (!ok) begin errs++; $display("FAIL c_drain: got busy=%b expected 0", c_busy); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_ss = 2'b11;
    req1_valid = 1'b0; req1_data = '0; req1_ss = 2'b11;
    loopback = 1'b0; miso_drv = 1'b0;
    c_req0_valid = 1'b0; c_req0_data = '0; c_req0_ss = 2'b11;
    c_req1_valid = 1'b0; c_req1_data = '0; c_req1_ss = 2'b11;
    c_spi_miso = 1'b0;
    test_reset();
    test_single();
    test_loopback();
    test_round_robin();
    test_reset_mid();
    test_ss_dummy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
